// File: rtl/wb_arb_pkg.sv
// Shared types and parameter defaults for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int unsigned MDU_FIFO_DEPTH_DEF = 4;
  localparam int unsigned STARVE_LIMIT_DEF   = 8;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_DBG, SRC_PIPE, SRC_MDU} wb_src_e;

endpackage

// File: rtl/wb_mdu_fifo.sv
// MDU result buffer: synchronous FIFO with occupancy count and two destination-register
// compare ports used for the ID-stage pending lookup.
module wb_mdu_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned  DEPTH = MDU_FIFO_DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [4:0]       push_rd,
  input  logic [31:0]      push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic [CNT_W-1:0] count,
  input  logic [4:0]       cmp_a,
  input  logic [4:0]       cmp_b,
  output logic             hit_a,
  output logic             hit_b
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Per-entry valid bit doubles as the non-empty flag at the head and as the lookup qualifier.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        mem_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push) begin
        mem_q[wr_ptr_q].valid <= 1'b1;
        mem_q[wr_ptr_q].rd    <= push_rd;
        mem_q[wr_ptr_q].data  <= push_data;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && (mem_q[i].rd == cmp_a) && (cmp_a != '0)) hit_a = 1'b1;
      if (mem_q[i].valid && (mem_q[i].rd == cmp_b) && (cmp_b != '0)) hit_b = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port owner: arbitrates debug, pipeline writeback and buffered MDU results.
// Optional WBARB_BYPASS_EN lets an MDU result skip the empty FIFO when the pipe is idle.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned  MDU_FIFO_DEPTH = MDU_FIFO_DEPTH_DEF,
  parameter int unsigned  STARVE_LIMIT   = STARVE_LIMIT_DEF,
  localparam int unsigned CNT_W          = $clog2(MDU_FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             debug,
  input  logic             pipe_wr_valid,
  input  logic [4:0]       pipe_rd,
  input  logic [31:0]      pipe_wdata,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [4:0]       mdu_rd,
  input  logic [31:0]      mdu_wdata,
  input  logic             dbg_wr_valid,
  input  logic [4:0]       dbg_rd,
  input  logic [31:0]      dbg_wdata,
  input  logic [4:0]       lookup_rs1,
  input  logic [4:0]       lookup_rs2,
  output logic             rs1_pending,
  output logic             rs2_pending,
  output logic             wb_hold,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_wdata,
  output logic [CNT_W-1:0] fifo_count,
  output logic             proto_err
);

  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t          head, winner;
  wb_src_e          src;
  logic             fifo_full, push, pop, bypass;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             hold_q, hold_d, err_q, err_d;
  logic             rf_we_q;
  logic [4:0]       rf_rd_q;
  logic [31:0]      rf_wdata_q;

  wb_mdu_fifo #(
    .DEPTH (MDU_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .Rst_n     (Rst_n),
    .push      (push),
    .push_rd   (mdu_rd),
    .push_data (mdu_wdata),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .count     (fifo_count),
    .cmp_a     (lookup_rs1),
    .cmp_b     (lookup_rs2),
    .hit_a     (rs1_pending),
    .hit_b     (rs2_pending)
  );

  assign mdu_ready = !debug && !fifo_full;

  always_comb begin
    src    = SRC_NONE;
    bypass = 1'b0;
    if (debug) begin
      if (dbg_wr_valid) src = SRC_DBG;
    end else if (pipe_wr_valid) begin
      src = SRC_PIPE;
    end else if (head.valid) begin
      src = SRC_MDU;
`ifdef WBARB_BYPASS_EN
    end else if (mdu_valid && mdu_ready) begin
      src    = SRC_MDU;
      bypass = 1'b1;
`endif
    end
  end

  always_comb begin
    winner = '0;
    unique case (src)
      SRC_DBG:  winner = '{valid: 1'b1, rd: dbg_rd, data: dbg_wdata};
      SRC_PIPE: winner = '{valid: 1'b1, rd: pipe_rd, data: pipe_wdata};
      SRC_MDU:  winner = bypass ? '{valid: 1'b1, rd: mdu_rd, data: mdu_wdata} : head;
      default:  winner = '0;
    endcase
  end

  assign pop  = (src == SRC_MDU) && !bypass;
  assign push = mdu_valid && mdu_ready && !bypass;

  // Debug freezes the starvation state; a pop always releases the hold.
  always_comb begin
    starve_d = starve_q;
    hold_d   = hold_q;
    if (!debug) begin
      if (pop) begin
        starve_d = '0;
        hold_d   = 1'b0;
      end else if (!head.valid) begin
        starve_d = '0;
      end else if (starve_q == STV_W'(STARVE_LIMIT)) begin
        hold_d = 1'b1;
      end else begin
        starve_d = starve_q + STV_W'(1);
      end
    end
  end

  assign err_d = err_q || (!debug && hold_q && pipe_wr_valid);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      starve_q   <= '0;
      hold_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q <= winner.valid && (winner.rd != '0);
      if (winner.valid) begin
        rf_rd_q    <= winner.rd;
        rf_wdata_q <= winner.data;
      end
      starve_q <= starve_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign wb_hold   = hold_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        debug = 1'b0;
  logic        pipe_wr_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_wdata = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_wdata = '0;
  logic        dbg_wr_valid = 1'b0;
  logic [4:0]  dbg_rd = '0;
  logic [31:0] dbg_wdata = '0;
  logic [4:0]  lookup_rs1 = '0;
  logic [4:0]  lookup_rs2 = '0;
  logic        rs1_pending, rs2_pending, wb_hold, rf_we, proto_err;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .MDU_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk           (clk),
    .Rst_n         (Rst_n),
    .debug         (debug),
    .pipe_wr_valid (pipe_wr_valid),
    .pipe_rd       (pipe_rd),
    .pipe_wdata    (pipe_wdata),
    .mdu_valid     (mdu_valid),
    .mdu_ready     (mdu_ready),
    .mdu_rd        (mdu_rd),
    .mdu_wdata     (mdu_wdata),
    .dbg_wr_valid  (dbg_wr_valid),
    .dbg_rd        (dbg_rd),
    .dbg_wdata     (dbg_wdata),
    .lookup_rs1    (lookup_rs1),
    .lookup_rs2    (lookup_rs2),
    .rs1_pending   (rs1_pending),
    .rs2_pending   (rs2_pending),
    .wb_hold       (wb_hold),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .fifo_count    (fifo_count),
    .proto_err     (proto_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queued MDU results, losing streak of the head, hold/error flags, port.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          streak;
  bit          m_hold, m_err, m_we, last_acc;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;

  task automatic model_reset();
    mq.delete();
    streak  = 0;
    m_hold  = 1'b0;
    m_err   = 1'b0;
    m_we    = 1'b0;
    m_rd    = '0;
    m_wdata = '0;
  endtask

  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    debug         = 1'b0;
    pipe_wr_valid = 1'b0;
    mdu_valid     = 1'b0;
    dbg_wr_valid  = 1'b0;
    lookup_rs1    = '0;
    lookup_rs2    = '0;
  endtask

  // Called just after an active edge with inputs driven; advances one clock.
  task automatic step();
    bit         rdy, acc, pop, byp, wv, lose;
    logic [4:0] wr;
    logic [31:0] wd;
    ent_t       e;
    #1;
    rdy = !debug && (mq.size() < DEPTH);
    check_eq("mdu_ready", {31'd0, mdu_ready}, {31'd0, rdy});
    check_eq("fifo_count", {29'd0, fifo_count}, mq.size());
    check_eq("rs1_pending", {31'd0, rs1_pending}, {31'd0, pend(lookup_rs1)});
    check_eq("rs2_pending", {31'd0, rs2_pending}, {31'd0, pend(lookup_rs2)});
    acc = mdu_valid && rdy;
    pop = 1'b0; byp = 1'b0; wv = 1'b0; wr = '0; wd = '0;
    if (debug) begin
      if (dbg_wr_valid) begin wv = 1'b1; wr = dbg_rd; wd = dbg_wdata; end
    end else if (pipe_wr_valid) begin
      wv = 1'b1; wr = pipe_rd; wd = pipe_wdata;
    end else if (mq.size() != 0) begin
      wv = 1'b1; wr = mq[0].rd; wd = mq[0].data; pop = 1'b1;
`ifdef WBARB_BYPASS_EN
    end else if (acc) begin
      wv = 1'b1; wr = mdu_rd; wd = mdu_wdata; byp = 1'b1;
`endif
    end
    if (!debug) begin
      if (pipe_wr_valid && m_hold) m_err = 1'b1;
      lose = (mq.size() != 0) && !pop;
      if (pop) m_hold = 1'b0;
      // The counter saturates at LIMIT; a further loss with it saturated raises the hold.
      if (lose && streak >= LIMIT) m_hold = 1'b1;
      streak = lose ? streak + 1 : 0;
    end
    if (pop) void'(mq.pop_front());
    if (acc && !byp) begin
      e.rd = mdu_rd; e.data = mdu_wdata;
      mq.push_back(e);
    end
    m_we = wv && (wr != 5'd0);
    if (wv) begin m_rd = wr; m_wdata = wd; end
    last_acc = acc;
    @(posedge clk);
    #1;
    check_eq("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    check_eq("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
    check_eq("rf_wdata", rf_wdata, m_wdata);
    check_eq("wb_hold", {31'd0, wb_hold}, {31'd0, m_hold});
    check_eq("proto_err", {31'd0, proto_err}, {31'd0, m_err});
  endtask

  task automatic mdu_offer(input logic [4:0] rd, input logic [31:0] data);
    mdu_valid = 1'b1; mdu_rd = rd; mdu_wdata = data;
  endtask

  task automatic busy_pipe();
    pipe_wr_valid = !m_hold;
    pipe_rd       = 5'($urandom_range(31, 1));
    pipe_wdata    = $urandom;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    Rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input int p_pipe, input int p_mdu, input int p_dbg, input bit violate);
    debug         = ($urandom_range(99) < p_dbg);
    dbg_wr_valid  = 1'($urandom_range(1));
    dbg_rd        = 5'($urandom_range(7));
    dbg_wdata     = $urandom;
    pipe_wr_valid = ($urandom_range(99) < p_pipe) && (violate || debug || !m_hold);
    pipe_rd       = 5'($urandom_range(7));
    pipe_wdata    = $urandom;
    if (!mdu_valid && $urandom_range(99) < p_mdu)
      mdu_offer(5'($urandom_range(7)), $urandom);
    if (mq.size() != 0 && $urandom_range(1) == 1)
      lookup_rs1 = mq[$urandom_range(mq.size() - 1)].rd;
    else
      lookup_rs1 = 5'($urandom_range(7));
    lookup_rs2 = 5'($urandom_range(7));
    step();
    if (last_acc) mdu_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_eq("reset_rf_we", {31'd0, rf_we}, 32'd0);
    check_eq("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
    check_eq("reset_rf_wdata", rf_wdata, 32'd0);
    check_eq("reset_wb_hold", {31'd0, wb_hold}, 32'd0);
    check_eq("reset_proto_err", {31'd0, proto_err}, 32'd0);
    check_eq("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
    #2;
    Rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single MDU result with idle pipe.
    step();
    lookup_rs1 = 5'd5;
    mdu_offer(5'd5, 32'hDEAD_BEEF);
    step();
    mdu_valid = 1'b0;
`ifndef WBARB_BYPASS_EN
    check_eq("basic_no_early_we", {31'd0, rf_we}, 32'd0);
    step();
`endif
    check_eq("basic_we", {31'd0, rf_we}, 32'd1);
    check_eq("basic_rd", {27'd0, rf_rd}, 32'd5);
    check_eq("basic_data", rf_wdata, 32'hDEAD_BEEF);
    step();

    // Starvation: one queued result behind a continuously busy pipe.
    mdu_offer(5'd9, 32'h0000_0099);
    busy_pipe();
    step();
    mdu_valid = 1'b0;
    for (int i = 0; i < 2 * LIMIT && !m_hold; i++) begin
      busy_pipe();
      step();
    end
    check_eq("starve_hold_set", {31'd0, wb_hold}, 32'd1);
    busy_pipe();
    step();
    check_eq("starve_mdu_write_rd", {27'd0, rf_rd}, 32'd9);
    check_eq("starve_hold_clear", {31'd0, wb_hold}, 32'd0);

    // Fill the FIFO while the pipe is busy, then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      mdu_offer(5'(i), 32'h100 + 32'(i));
      busy_pipe();
      step();
    end
    mdu_valid = 1'b0;
    #1;
    check_eq("fill_count", {29'd0, fifo_count}, 32'd4);
    check_eq("fill_ready", {31'd0, mdu_ready}, 32'd0);
    pipe_wr_valid = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      check_eq("drain_order", {27'd0, rf_rd}, 32'(i));
    end

    // rd=0 result is consumed without a write.
    mdu_offer(5'd0, 32'h0BAD_0000);
    step();
    mdu_valid = 1'b0;
    step();
    check_eq("rd0_no_we", {31'd0, rf_we}, 32'd0);
    check_eq("rd0_drained", {29'd0, fifo_count}, 32'd0);

    // Debug write with a frozen queued entry.
    mdu_offer(5'd3, 32'h3333);
    busy_pipe();
    step();
    mdu_valid = 1'b0;
    debug = 1'b1; dbg_wr_valid = 1'b1; dbg_rd = 5'd7; dbg_wdata = 32'h1234;
    step();
    check_eq("dbg_rd", {27'd0, rf_rd}, 32'd7);
    check_eq("dbg_data", rf_wdata, 32'h1234);
    debug = 1'b0; dbg_wr_valid = 1'b0; pipe_wr_valid = 1'b0;
    step();
    check_eq("dbg_resume_rd", {27'd0, rf_rd}, 32'd3);

    // Asynchronous reset in the middle of a drain.
    for (int i = 1; i <= DEPTH; i++) begin
      mdu_offer(5'(i + 10), $urandom);
      busy_pipe();
      step();
    end
    mdu_valid = 1'b0;
    pipe_wr_valid = 1'b0;
    step();
    #3;
    Rst_n = 1'b0;
    #1;
    check_eq("async_count", {29'd0, fifo_count}, 32'd0);
    check_eq("async_we", {31'd0, rf_we}, 32'd0);
    check_eq("async_hold", {31'd0, wb_hold}, 32'd0);
    do_reset();

    // Hold-contract violation: pipe keeps writing while held.
    mdu_offer(5'd4, 32'h4444);
    pipe_wr_valid = 1'b1; pipe_rd = 5'd6;
    for (int i = 0; i < LIMIT + 4; i++) begin
      pipe_wdata = 32'h6000 + 32'(i);
      step();
      mdu_valid = 1'b0;
    end
    check_eq("viol_err", {31'd0, proto_err}, 32'd1);
    check_eq("viol_pipe_we", {31'd0, rf_we}, 32'd1);
    check_eq("viol_pipe_data", rf_wdata, 32'h6000 + 32'(LIMIT + 3));
    for (int i = 0; i < 100; i++) rand_cycle(100, 50, 0, 1'b1);
    do_reset();

    // Randomized phases with the hold contract honoured.
    for (int i = 0; i < 400; i++) rand_cycle(90, 60, 5, 1'b0);
    for (int i = 0; i < 400; i++) rand_cycle(25, 50, 0, 1'b0);
    for (int i = 0; i < 400; i++) rand_cycle(60, 70, 25, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
